// File: rtl/io_int_sched.sv
// io_int_sched: interrupt scheduler for the Pacoblaze I/O subsystem.
// Collects rising-edge requests from up to 8 peripheral sources and presents
// one at a time on the interrupt/interrupt_ack handshake. The mask, pending,
// vector and end-of-interrupt registers are visible as I/O ports.
//
// Optional build macro IO_INT_SCHED_RR_EN selects round-robin arbitration
// (search starts one past the last granted source). Without it, the lowest
// index wins and no last-granted register exists.
module io_int_sched #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] ADDR_MASK = 8'h10,
  parameter logic [7:0] ADDR_PEND = 8'h11,
  parameter logic [7:0] ADDR_VEC  = 8'h12,
  parameter logic [7:0] ADDR_EOI  = 8'h13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_port_id,
  input  logic [7:0]       i_port_in,
  input  logic             i_wen,
  input  logic             i_ren,
  output logic [7:0]       o_port_out,
  input  logic [N_SRC-1:0] i_src_req,
  output logic [N_SRC-1:0] o_src_ack,
  output logic             o_interrupt,
  input  logic             i_interrupt_ack
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_id;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_req_d;
  logic [N_SRC-1:0] r_src_ack;

  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_eoi;
  logic             w_grant;
  logic             w_busy;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_cand;
  logic [N_SRC-1:0] w_id_onehot;
  logic [N_SRC-1:0] w_pend_next;
  logic [2:0]       w_win_id;
  logic [7:0]       w_rdata;
  logic             w_unused;

  // Reads have no side effects, so the read strobe carries no information here.
  assign w_unused = ^{i_ren, i_port_in};

  assign w_wr_mask = i_wen && (i_port_id == ADDR_MASK);
  assign w_wr_pend = i_wen && (i_port_id == ADDR_PEND);
  assign w_eoi     = i_wen && (i_port_id == ADDR_EOI) && (r_state == S_SERVICE);
  assign w_grant   = (r_state == S_REQ) && i_interrupt_ack;
  assign w_busy    = (r_state == S_SERVICE);

  assign w_set  = i_src_req & ~r_req_d;
  assign w_cand = r_pend & r_mask;

  assign o_interrupt = (r_state == S_REQ);
  assign o_src_ack   = r_src_ack;
  assign o_port_out  = w_rdata;

  // Decode the latched id into a per-source select for pend clearing and acks.
  always_comb begin
    w_id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_id_onehot[i] = (r_id == 3'(i));
    end
  end

  // Next pending value: W1C and grant clear first, then new edges set, so a set always wins.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr_pend) begin
      w_pend_next = w_pend_next & ~i_port_in[N_SRC-1:0];
    end
    if (w_grant) begin
      w_pend_next = w_pend_next & ~w_id_onehot;
    end
    w_pend_next = w_pend_next | w_set;
  end

`ifdef IO_INT_SCHED_RR_EN
  logic [2:0] r_last;
  logic [2:0] w_start;
  logic       w_hi_found;
  logic [2:0] w_hi_id;
  logic [2:0] w_lo_id;

  assign w_start = (r_last == 3'(N_SRC - 1)) ? 3'd0 : (r_last + 3'd1);

  // Round-robin: lowest candidate at or above the start point, else lowest below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = 3'd0;
    w_lo_id    = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        if (3'(i) >= w_start) begin
          w_hi_found = 1'b1;
          w_hi_id    = 3'(i);
        end else begin
          w_lo_id = 3'(i);
        end
      end
    end
    w_win_id = w_hi_found ? w_hi_id : w_lo_id;
  end

  // Remember the most recently acknowledged source to rotate the search start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 3'(N_SRC - 1);
    end else if (w_grant) begin
      r_last <= r_id;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest active index as winner.
  always_comb begin
    w_win_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_id = 3'(i);
      end
    end
  end
`endif

  // Request edge detection and the mask/pending registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_d <= '0;
      r_mask  <= '0;
      r_pend  <= '0;
    end else begin
      r_req_d <= i_src_req;
      r_pend  <= w_pend_next;
      if (w_wr_mask) begin
        r_mask <= i_port_in[N_SRC-1:0];
      end
    end
  end

  // Handshake FSM; the id is latched once in IDLE and held until the next IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_id    <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cand != '0) begin
            r_id    <= w_win_id;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_interrupt_ack) begin
            r_state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (w_eoi) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-cycle acknowledge pulse back to the source being serviced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src_ack <= '0;
    end else begin
      r_src_ack <= w_grant ? w_id_onehot : '0;
    end
  end

  // Read mux; unaddressed ports and the write-only EOI port read as zero.
  always_comb begin
    w_rdata = 8'h00;
    case (i_port_id)
      ADDR_MASK: w_rdata = 8'(r_mask);
      ADDR_PEND: w_rdata = 8'(r_pend);
      ADDR_VEC:  w_rdata = {w_busy, 4'b0000, r_id};
      default:   w_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_io_int_sched.sv
// tb_io_int_sched: directed self-checking bench for io_int_sched (N_SRC=4).
// Builds with or without IO_INT_SCHED_RR_EN; the priority scenario's expected
// grant order follows the selected arbitration mode.
module tb_io_int_sched;

  localparam logic [7:0] A_MASK = 8'h10;
  localparam logic [7:0] A_PEND = 8'h11;
  localparam logic [7:0] A_VEC  = 8'h12;
  localparam logic [7:0] A_EOI  = 8'h13;

  logic       clk;
  logic       rst_n;
  logic [7:0] port_id;
  logic [7:0] port_in;
  logic       wen;
  logic       ren;
  logic [7:0] port_out;
  logic [3:0] src_req;
  logic [3:0] src_ack;
  logic       interrupt;
  logic       interrupt_ack;

  int total = 0;
  int bad   = 0;

  io_int_sched #(.N_SRC(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_port_id       (port_id),
    .i_port_in       (port_in),
    .i_wen           (wen),
    .i_ren           (ren),
    .o_port_out      (port_out),
    .i_src_req       (src_req),
    .o_src_ack       (src_ack),
    .o_interrupt     (interrupt),
    .i_interrupt_ack (interrupt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    port_id = addr;
    port_in = data;
    wen     = 1'b1;
    tick();
    wen     = 1'b0;
    port_in = 8'h00;
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    port_id = addr;
    ren     = 1'b1;
    #1;
    data    = port_out;
    ren     = 1'b0;
  endtask

  task automatic do_ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b expected 0", interrupt); end
    total++; if (src_ack !== 4'h0) begin bad++; $display("[TB] FAIL reset_ack: got %h expected 0", src_ack); end
    rst_n = 1'b1;
    tick();
    io_read(A_MASK, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_mask: got %h expected 00", d); end
    io_read(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_pend: got %h expected 00", d); end
    io_read(A_VEC, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_vec: got %h expected 00", d); end
  endtask

  task automatic test_basic_grant();
    logic [7:0] d;
    io_write(A_MASK, 8'h0F);
    io_read(A_MASK, d);
    total++; if (d !== 8'h0F) begin bad++; $display("[TB] FAIL mask_rd: got %h expected 0f", d); end
    src_req = 4'b0100;
    tick();
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL irq_t1: got %b expected 0", interrupt); end
    io_read(A_PEND, d);
    total++; if (d !== 8'h04) begin bad++; $display("[TB] FAIL pend_set: got %h expected 04", d); end
    tick();
    total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL irq_t2: got %b expected 1", interrupt); end
    io_read(A_VEC, d);
    total++; if (d !== 8'h02) begin bad++; $display("[TB] FAIL vec_req: got %h expected 02", d); end
    io_read(8'h14, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL unmapped_rd: got %h expected 00", d); end
    io_write(A_EOI, 8'h00);
    total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL eoi_in_req: got %b expected 1", interrupt); end
    do_ack();
    total++; if (src_ack !== 4'b0100) begin bad++; $display("[TB] FAIL ack_pulse: got %h expected 4", src_ack); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL irq_after_ack: got %b expected 0", interrupt); end
    io_read(A_VEC, d);
    total++; if (d !== 8'h82) begin bad++; $display("[TB] FAIL vec_busy: got %h expected 82", d); end
    io_read(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL pend_cleared: got %h expected 00", d); end
    tick();
    total++; if (src_ack !== 4'b0000) begin bad++; $display("[TB] FAIL ack_one_cycle: got %h expected 0", src_ack); end
    src_req = 4'b0000;
    io_write(A_EOI, 8'hA5);
    io_read(A_VEC, d);
    total++; if (d !== 8'h02) begin bad++; $display("[TB] FAIL vec_after_eoi: got %h expected 02", d); end
    tick();
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_irq: got %b expected 0", interrupt); end
  endtask

  task automatic test_mask_gate();
    logic [7:0] d;
    io_write(A_MASK, 8'h00);
    src_req = 4'b0010;
    tick();
    src_req = 4'b0000;
    io_read(A_PEND, d);
    total++; if (d !== 8'h02) begin bad++; $display("[TB] FAIL masked_pend: got %h expected 02", d); end
    tick();
    tick();
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL masked_irq: got %b expected 0", interrupt); end
    io_write(A_MASK, 8'h02);
    tick();
    total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL unmask_irq: got %b expected 1", interrupt); end
    io_read(A_VEC, d);
    total++; if (d !== 8'h01) begin bad++; $display("[TB] FAIL unmask_vec: got %h expected 01", d); end
    io_write(A_MASK, 8'h00);
    total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL mask_off_in_req: got %b expected 1", interrupt); end
    do_ack();
    total++; if (src_ack !== 4'b0010) begin bad++; $display("[TB] FAIL mask_off_ack: got %h expected 2", src_ack); end
    io_write(A_EOI, 8'h00);
  endtask

  task automatic test_priority();
    logic [7:0] d;
    logic [7:0] vec2;
    logic [7:0] vec3;
`ifdef IO_INT_SCHED_RR_EN
    vec2 = 8'h03;
    vec3 = 8'h00;
`else
    vec2 = 8'h00;
    vec3 = 8'h03;
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    io_write(A_MASK, 8'h0F);
    src_req = 4'b1001;
    tick();
    src_req = 4'b0000;
    io_read(A_PEND, d);
    total++; if (d !== 8'h09) begin bad++; $display("[TB] FAIL prio_pend: got %h expected 09", d); end
    tick();
    io_read(A_VEC, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL prio_first: got %h expected 00", d); end
    do_ack();
    total++; if (src_ack !== 4'b0001) begin bad++; $display("[TB] FAIL prio_first_ack: got %h expected 1", src_ack); end
    src_req = 4'b0001;
    tick();
    src_req = 4'b0000;
    io_read(A_PEND, d);
    total++; if (d !== 8'h09) begin bad++; $display("[TB] FAIL service_accum: got %h expected 09", d); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL service_no_irq: got %b expected 0", interrupt); end
    io_write(A_EOI, 8'h00);
    tick();
    total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL eoi_latency: got %b expected 1", interrupt); end
    io_read(A_VEC, d);
    total++; if (d !== vec2) begin bad++; $display("[TB] FAIL prio_second: got %h expected %h", d, vec2); end
    do_ack();
    total++; if (src_ack !== ((vec2 == 8'h03) ? 4'b1000 : 4'b0001)) begin bad++; $display("[TB] FAIL prio_second_ack: got %h", src_ack); end
    io_write(A_EOI, 8'h00);
    tick();
    io_read(A_VEC, d);
    total++; if (d !== vec3) begin bad++; $display("[TB] FAIL prio_third: got %h expected %h", d, vec3); end
    do_ack();
    io_read(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL prio_drained: got %h expected 00", d); end
    io_write(A_EOI, 8'h00);
  endtask

  task automatic test_w1c_race();
    logic [7:0] d;
    io_write(A_MASK, 8'h00);
    src_req = 4'b0011;
    tick();
    src_req = 4'b0000;
    tick();
    io_read(A_PEND, d);
    total++; if (d !== 8'h03) begin bad++; $display("[TB] FAIL w1c_setup: got %h expected 03", d); end
    port_id = A_PEND;
    port_in = 8'h02;
    wen     = 1'b1;
    src_req = 4'b0010;
    tick();
    wen     = 1'b0;
    port_in = 8'h00;
    src_req = 4'b0000;
    io_read(A_PEND, d);
    total++; if (d !== 8'h03) begin bad++; $display("[TB] FAIL set_beats_w1c: got %h expected 03", d); end
    io_write(A_PEND, 8'h02);
    io_read(A_PEND, d);
    total++; if (d !== 8'h01) begin bad++; $display("[TB] FAIL w1c_clear: got %h expected 01", d); end
    src_req = 4'b0001;
    tick();
    src_req = 4'b0000;
    io_read(A_PEND, d);
    total++; if (d !== 8'h01) begin bad++; $display("[TB] FAIL merge_edge: got %h expected 01", d); end
    io_write(A_PEND, 8'hFF);
    io_read(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL w1c_all: got %h expected 00", d); end
  endtask

  task automatic test_reset_in_service();
    logic [7:0] d;
    io_write(A_MASK, 8'h0F);
    src_req = 4'b0001;
    tick();
    src_req = 4'b0000;
    tick();
    do_ack();
    src_req = 4'b0100;
    tick();
    src_req = 4'b0000;
    io_read(A_VEC, d);
    total++; if (d !== 8'h80) begin bad++; $display("[TB] FAIL svc_vec: got %h expected 80", d); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq: got %b expected 0", interrupt); end
    io_read(A_MASK, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL rst_mask: got %h expected 00", d); end
    io_read(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL rst_pend: got %h expected 00", d); end
    io_read(A_VEC, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL rst_vec: got %h expected 00", d); end
    tick();
    rst_n = 1'b1;
    interrupt_ack = 1'b1;
    tick();
    total++; if (src_ack !== 4'b0000) begin bad++; $display("[TB] FAIL stray_ack: got %h expected 0", src_ack); end
    interrupt_ack = 1'b0;
    io_write(A_EOI, 8'h00);
    total++; if (src_ack !== 4'b0000) begin bad++; $display("[TB] FAIL stray_eoi: got %h expected 0", src_ack); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL stray_irq: got %b expected 0", interrupt); end
  endtask

  initial begin
    rst_n         = 1'b0;
    port_id       = 8'h00;
    port_in       = 8'h00;
    wen           = 1'b0;
    ren           = 1'b0;
    src_req       = 4'b0000;
    interrupt_ack = 1'b0;
    test_reset();
    test_basic_grant();
    test_mask_gate();
    test_priority();
    test_w1c_race();
    test_reset_in_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
